// File: rtl/uartprobe_multi.sv
// uartprobe_multi: UART byte-stream debug probe exposing NBYTES of GPI/GPO.
// Commands arrive on the rx byte channel and responses leave on the tx channel.
// Opcodes: ping, GPI/GPO byte read, GPO write/set/clear, coherent GPI burst.
module uartprobe_multi #(
  parameter int unsigned         NBYTES    = 4,
  parameter logic [8*NBYTES-1:0] GPO_RESET = '0,
  parameter logic [7:0]          ID        = 8'h50,
  parameter int unsigned         TIMEOUT   = 1024,
  parameter bit                  ACK_WR    = 1'b0
) (
  input  logic                clk,
  input  logic                m_aresetn,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready,
  input  logic [8*NBYTES-1:0] gpi,
  output logic [8*NBYTES-1:0] gpo,
  output logic                busy
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] OP_PING    = 3'd0;
  localparam logic [2:0] OP_GPI_RD  = 3'd1;
  localparam logic [2:0] OP_GPO_RD  = 3'd2;
  localparam logic [2:0] OP_GPO_WR  = 3'd3;
  localparam logic [2:0] OP_GPO_SET = 3'd4;
  localparam logic [2:0] OP_GPO_CLR = 3'd5;
  localparam logic [2:0] OP_BURST   = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  localparam logic [7:0] NACK_CMD = 8'hEE;
  localparam logic [7:0] NACK_TMO = 8'hEF;
  localparam logic [7:0] ACK      = 8'hAC;

  typedef enum logic [2:0] {
    S_IDLE, S_OPERAND, S_EXEC, S_RESP, S_BURST
  } state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [4:0]  idx_q;
  logic [7:0]  opnd_q;
  logic [15:0] cnt_q;
  logic [7:0]  bcnt_q;
  logic [4:0]  bidx_q;
  logic        rx_ready_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  gpo_q  [NBYTES];
  logic [7:0]  snap_q [NBYTES];

  logic [NBYTES-1:0][7:0] gpi_b;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_idx;
  logic        cmd_in_rng, cmd_illegal, cmd_has_opnd;
  logic        rx_acc, tx_acc, wr_en, snap_en;
  logic [16:0] cnt_nxt;
  logic [7:0]  rd_byte;

  assign gpi_b        = gpi;
  assign cmd_op       = rx_data[7:5];
  assign cmd_idx      = rx_data[4:0];
  assign cmd_in_rng   = (32'(cmd_idx) < NBYTES);
  assign cmd_illegal  = (cmd_op == OP_RSVD) || !cmd_in_rng ||
                        ((cmd_op == OP_PING) && (cmd_idx != 5'd0));
  assign cmd_has_opnd = (cmd_op == OP_GPO_WR) || (cmd_op == OP_GPO_SET) ||
                        (cmd_op == OP_GPO_CLR) || (cmd_op == OP_BURST);
  assign rx_acc       = rx_valid && rx_ready_q;
  assign tx_acc       = tx_valid_q && tx_ready;
  assign wr_en        = (state_q == S_EXEC) &&
                        ((op_q == OP_GPO_WR) || (op_q == OP_GPO_SET) || (op_q == OP_GPO_CLR));
  assign snap_en      = (state_q == S_EXEC) && (op_q == OP_BURST);
  // Count that will be reached on this edge if no operand shows up.
  assign cnt_nxt      = {1'b0, cnt_q} + 17'd1;

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != S_IDLE);

  // Wrap-around byte index increment for bursts.
  function automatic logic [4:0] nxt_idx(input logic [4:0] i);
    return (32'(i) == NBYTES - 1) ? 5'd0 : i + 5'd1;
  endfunction

  // Immediate response byte for single-byte commands (only used when legal).
  always_comb begin
    rd_byte = ID;
    case (cmd_op)
      OP_GPI_RD: rd_byte = gpi_b[cmd_idx[IW-1:0]];
      OP_GPO_RD: rd_byte = gpo_q[cmd_idx[IW-1:0]];
      default:   rd_byte = ID;
    endcase
  end

  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    // Per-byte GPO register: write/set/clear of the addressed byte in EXEC.
    always_ff @(posedge clk or negedge m_aresetn) begin
      if (!m_aresetn) begin
        gpo_q[b] <= GPO_RESET[8*b +: 8];
      end else if (wr_en && (idx_q == 5'(b))) begin
        case (op_q)
          OP_GPO_WR:  gpo_q[b] <= opnd_q;
          OP_GPO_SET: gpo_q[b] <= gpo_q[b] | opnd_q;
          default:    gpo_q[b] <= gpo_q[b] & ~opnd_q;
        endcase
      end
    end

    // Burst snapshot: all of GPI captured once so the burst is coherent.
    always_ff @(posedge clk or negedge m_aresetn) begin
      if (!m_aresetn)   snap_q[b] <= 8'h00;
      else if (snap_en) snap_q[b] <= gpi_b[b];
    end

    assign gpo[8*b +: 8] = gpo_q[b];
  end

  // Control FSM; all handshake outputs are registered.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      idx_q      <= 5'd0;
      opnd_q     <= 8'h00;
      cnt_q      <= 16'd0;
      bcnt_q     <= 8'd0;
      bidx_q     <= 5'd0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_acc) begin
            op_q  <= cmd_op;
            idx_q <= cmd_idx;
            cnt_q <= 16'd0;
            if (cmd_illegal) begin
              state_q    <= S_RESP;
              rx_ready_q <= 1'b0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= NACK_CMD;
            end else if (cmd_has_opnd) begin
              state_q <= S_OPERAND;
            end else begin
              state_q    <= S_RESP;
              rx_ready_q <= 1'b0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= rd_byte;
            end
          end
        end
        S_OPERAND: begin
          // An operand on the timeout edge wins over the timeout.
          if (rx_acc) begin
            opnd_q     <= rx_data;
            state_q    <= S_EXEC;
            rx_ready_q <= 1'b0;
          end else if ((TIMEOUT != 0) && (cnt_nxt == 17'(TIMEOUT))) begin
            state_q    <= S_RESP;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= NACK_TMO;
          end else begin
            cnt_q <= cnt_nxt[15:0];
          end
        end
        S_EXEC: begin
          if (op_q == OP_BURST) begin
            if (opnd_q == 8'd0) begin
              state_q    <= S_IDLE;
              rx_ready_q <= 1'b1;
            end else begin
              // First byte comes straight from gpi, identical to the snapshot.
              state_q    <= S_BURST;
              tx_valid_q <= 1'b1;
              tx_data_q  <= gpi_b[idx_q[IW-1:0]];
              bcnt_q     <= opnd_q;
              bidx_q     <= nxt_idx(idx_q);
            end
          end else if (ACK_WR) begin
            state_q    <= S_RESP;
            tx_valid_q <= 1'b1;
            tx_data_q  <= ACK;
          end else begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (tx_acc) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b1;
          end
        end
        S_BURST: begin
          if (tx_acc) begin
            if (bcnt_q == 8'd1) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
              rx_ready_q <= 1'b1;
            end else begin
              bcnt_q    <= bcnt_q - 8'd1;
              tx_data_q <= snap_q[bidx_q[IW-1:0]];
              bidx_q    <= nxt_idx(bidx_q);
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
